// File: rtl/fft_frame_scheduler_if.sv
// Handshake bundle between the FFT frame scheduler and its channel muxes / FFT core.
// Parameters must match the scheduler instance that uses the interface.
interface fft_frame_scheduler_if #(
  parameter int N_CH      = 2,
  parameter int CFG_WIDTH = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]           i_req;
  logic [CFG_WIDTH*N_CH-1:0] i_cfg_data;
  logic [CFG_WIDTH-1:0]      o_cfg_data;
  logic                      o_cfg_valid;
  logic                      i_cfg_ready;
  logic [N_CH-1:0]           o_grant;
  logic [CH_W-1:0]           o_chan;
  logic                      i_beat;
  logic                      o_last;

  modport master (
    input  i_req, i_cfg_data, i_cfg_ready, i_beat,
    output o_cfg_data, o_cfg_valid, o_grant, o_chan, o_last
  );

  modport slave (
    output i_req, i_cfg_data, i_cfg_ready, i_beat,
    input  o_cfg_data, o_cfg_valid, o_grant, o_chan, o_last
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Round-robin scheduler sharing one FFT core between N_CH channels: issues a config
// word on channel change, then gates exactly FFT_LENGTH beats and flags the last one.
module fft_frame_scheduler #(
  parameter int N_CH       = 2,
  parameter int FFT_LENGTH = 2048,
  parameter int CFG_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_enable,
  fft_frame_scheduler_if.master bus,
  output logic                 o_busy,
  output logic [N_CH-1:0]      o_overrun,
  output logic [CNT_WIDTH-1:0] o_drop_count
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W = (FFT_LENGTH > 1) ? $clog2(FFT_LENGTH) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(FFT_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, CFG, STREAM} state_t;

  state_t               state;
  logic [N_CH-1:0]      pend;
  logic [N_CH-1:0]      take;
  logic [N_CH-1:0]      ovr_now;
  logic [CH_W-1:0]      rr_ptr;
  logic [CH_W-1:0]      sel;
  logic [CH_W-1:0]      pick;
  logic [CH_W-1:0]      last_cfg;
  logic                 last_cfg_vld;
  logic                 start;
  logic [BC_W-1:0]      beat_cnt;
  logic [CFG_WIDTH-1:0] cfg_data_q;
  logic                 cfg_valid_q;
  logic [N_CH-1:0]      grant_q;

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = (c == CH_W'(k));
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(N_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  assign start   = (state == IDLE) && i_enable && (|pend);
  assign take    = start ? onehot(pick) : '0;
  assign ovr_now = bus.i_req & pend & ~take;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      pend         <= '0;
      o_overrun    <= '0;
      o_drop_count <= '0;
    end else begin
      pend      <= (pend & ~take) | bus.i_req;
      o_overrun <= ovr_now;
      // Several simultaneous overruns still count as a single drop.
      if (|ovr_now) o_drop_count <= sat_inc(o_drop_count);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      sel          <= '0;
      last_cfg     <= '0;
      last_cfg_vld <= 1'b0;
      beat_cnt     <= '0;
      cfg_data_q   <= '0;
      cfg_valid_q  <= 1'b0;
      grant_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel        <= pick;
            cfg_data_q <= bus.i_cfg_data[int'(pick)*CFG_WIDTH +: CFG_WIDTH];
            beat_cnt   <= '0;
            if (last_cfg_vld && (last_cfg == pick)) begin
              grant_q <= onehot(pick);
              state   <= STREAM;
            end else begin
              cfg_valid_q <= 1'b1;
              state       <= CFG;
            end
          end
        end
        CFG: begin
          if (bus.i_cfg_ready) begin
            cfg_valid_q  <= 1'b0;
            last_cfg     <= sel;
            last_cfg_vld <= 1'b1;
            grant_q      <= onehot(sel);
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (bus.i_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              grant_q  <= '0;
              rr_ptr   <= next_ch(sel);
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_cfg_data  = cfg_data_q;
  assign bus.o_cfg_valid = cfg_valid_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_chan      = sel;
  assign bus.o_last      = (state == STREAM) && (beat_cnt == LAST_BEAT);
  assign o_busy          = (state != IDLE);
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized bench for fft_frame_scheduler against a frame-level reference model.
module tb_fft_frame_scheduler;
  localparam int N  = 2;
  localparam int L  = 8;
  localparam int CW = 16;
  localparam int DW = 6;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          busy;
  logic [N-1:0]  ovr;
  logic [DW-1:0] drops;

  always #5 clk = ~clk;

  fft_frame_scheduler_if #(.N_CH(N), .CFG_WIDTH(CW)) bus ();

  fft_frame_scheduler #(.N_CH(N), .FFT_LENGTH(L), .CFG_WIDTH(CW), .CNT_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_resetn     (rstn),
    .i_enable     (en),
    .bus          (bus),
    .o_busy       (busy),
    .o_overrun    (ovr),
    .o_drop_count (drops)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for config accept, 2 streaming.
  int             m_phase, m_sel, m_rr, m_lastcfg, m_beats, m_drops;
  bit             m_pend [N];
  bit             m_ovr  [N];
  logic [CW-1:0]  m_word;
  logic [CW-1:0]  cfgw   [N];
  bit             req    [N];

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_rr = 0; m_lastcfg = -1; m_beats = 0; m_drops = 0;
    m_word = '0;
    for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_ovr[k] = 0; end
  endtask

  task automatic model_step(input bit e, input bit rdy, input bit beat);
    int  taken;
    bit  any_pend;
    bit  any_ovr;
    taken = -1;
    any_pend = 0;
    for (int k = 0; k < N; k++) any_pend |= m_pend[k];
    if (m_phase == 0) begin
      if (e && any_pend) begin
        for (int i = N - 1; i >= 0; i--)
          if (m_pend[(m_rr + i) % N]) taken = (m_rr + i) % N;
        m_sel   = taken;
        m_word  = cfgw[taken];
        m_beats = 0;
        m_phase = (m_lastcfg == taken) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (rdy) begin m_lastcfg = m_sel; m_phase = 2; end
    end else begin
      if (beat) begin
        m_beats++;
        if (m_beats == L) begin m_beats = 0; m_phase = 0; m_rr = (m_sel + 1) % N; end
      end
    end
    any_ovr = 0;
    for (int k = 0; k < N; k++) begin
      m_ovr[k]  = req[k] && m_pend[k] && (k != taken);
      any_ovr  |= m_ovr[k];
      m_pend[k] = (m_pend[k] && (k != taken)) || req[k];
    end
    if (any_ovr && m_drops < DROP_MAX) m_drops++;
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg, eo;
    eg = '0; eo = '0;
    if (m_phase == 2) eg[m_sel] = 1'b1;
    for (int k = 0; k < N; k++) eo[k] = m_ovr[k];
    chk("grant",     64'(bus.o_grant),   64'(eg));
    chk("cfg_valid", 64'(bus.o_cfg_valid), 64'(m_phase == 1));
    if (m_phase == 1) chk("cfg_data", 64'(bus.o_cfg_data), 64'(m_word));
    chk("last",      64'(bus.o_last),    64'(m_phase == 2 && m_beats == L - 1));
    chk("busy",      64'(busy),          64'(m_phase != 0));
    chk("chan",      64'(bus.o_chan),    64'(m_sel));
    chk("overrun",   64'(ovr),           64'(eo));
    chk("drops",     64'(drops),         64'(m_drops));
  endtask

  initial begin
    int  req_div;
    bit  rdy, beat;
    rstn = 1'b0; en = 1'b0;
    bus.i_req = '0; bus.i_cfg_data = '0; bus.i_cfg_ready = 1'b0; bus.i_beat = 1'b0;
    for (int k = 0; k < N; k++) begin cfgw[k] = '0; req[k] = 0; end
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rstn = 1'b1;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      check_outputs();

      if (cyc > 400 && m_phase == 2 && $urandom_range(0, 60) == 0) begin
        rstn = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.o_grant), 64'd0);
        chk("rst_cfgv",  64'(bus.o_cfg_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_last",  64'(bus.o_last), 64'd0);
        chk("rst_drops", 64'(drops), 64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        check_outputs();
      end

      // Early window: always-ready, always-beat; later: stalls, disables, overrun bursts.
      if (cyc < 400) begin
        rdy = 1; beat = 1; en = 1'b1; req_div = 14;
      end else begin
        rdy  = ($urandom_range(0, 3) != 0);
        beat = ($urandom_range(0, 9) < 6);
        en   = ((cyc / 150) % 4) != 3;
        req_div = (cyc >= 3000 && cyc < 3800) ? 2 : 10;
      end
      for (int k = 0; k < N; k++) begin
        req[k]  = ($urandom_range(0, req_div - 1) == 0);
        cfgw[k] = CW'($urandom);
        bus.i_req[k] = req[k];
        bus.i_cfg_data[k*CW +: CW] = cfgw[k];
      end
      bus.i_cfg_ready = rdy;
      bus.i_beat      = beat;
      model_step(en, rdy, beat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
